// File: rtl/full_adder.sv
// Purpose: parameterisable ripple-carry adder {Cout,Sum} = A + B + Cin, with a registered copy and sticky carry status.
// Latency: Sum/Cout/Ovf are combinational (0 cycles); Sum_q/Cout_q/Ovf_q/carry_seen/carry_cnt update 1 cycle later.
// Backpressure: none; operands may change at any time and only the values present at a rising clk edge are captured.
//
// Ports:
//   clk        rising-edge clock for the registered outputs
//   rst        asynchronous active-high reset of all registered outputs
//   A, B       WIDTH-bit operands
//   Cin        carry into bit 0
//   Sum        combinational sum bits (low WIDTH bits of A+B+Cin)
//   Cout       combinational carry out of the MSB
//   Ovf        combinational two's-complement overflow (0 when SIGNED_OVF=0)
//   Sum_q      Sum captured on the last rising edge
//   Cout_q     Cout captured on the last rising edge
//   Ovf_q      Ovf captured on the last rising edge
//   carry_seen sticky: set by any rising edge that sees Cout=1
//   carry_cnt  number of rising edges that saw Cout=1, saturating at 16'hFFFF
module full_adder #(
    parameter int WIDTH      = 1,
    parameter bit SIGNED_OVF = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic [WIDTH-1:0] Sum_q,
    output logic             Cout_q,
    output logic             Ovf_q,
    output logic             carry_seen,
    output logic [15:0]      carry_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Explicit ripple chain. Each bit keeps its own carry-in/carry-out nets
    // inside its generate scope so the chain is a plain sequence of cells
    // rather than a vector that feeds back into itself.
    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_bit
        logic ci;
        logic co;

        if (i == 0) begin : g_lsb
            assign ci = Cin;
        end else begin : g_link
            assign ci = g_bit[i-1].co;
        end

        assign Sum[i] = A[i] ^ B[i] ^ ci;
        assign co     = (A[i] & B[i]) | (A[i] & ci) | (B[i] & ci);
    end

    assign Cout = g_bit[WIDTH-1].co;

    // Signed overflow is the disagreement between the carry into and out of
    // the sign bit. For WIDTH=1 the carry into the MSB is Cin itself.
    if (SIGNED_OVF) begin : g_ovf
        assign Ovf = g_bit[WIDTH-1].ci ^ g_bit[WIDTH-1].co;
    end else begin : g_no_ovf
        assign Ovf = 1'b0;
    end

    // Pipeline copy and carry statistics. Reset is asynchronous and takes
    // priority over a coincident clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Sum_q      <= '0;
            Cout_q     <= 1'b0;
            Ovf_q      <= 1'b0;
            carry_seen <= 1'b0;
            carry_cnt  <= '0;
        end else begin
            Sum_q  <= Sum;
            Cout_q <= Cout;
            Ovf_q  <= Ovf;
            if (Cout) begin
                carry_seen <= 1'b1;
                // Saturate rather than wrap so a long run never reads as few carries.
                if (carry_cnt != CNT_MAX) begin
                    carry_cnt <= carry_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: WIDTH=1, 8 and 16 instances driven with directed and
// random operands, checked against an arithmetic reference model.
module tb_full_adder;

    int total = 0;
    int bad   = 0;

    logic clk     = 1'b0;
    logic clk_run = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    // WIDTH=1 instance; rst1 stays unassigned until the reset tests
    logic       rst1;
    logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic [0:0] sum1, sum_q1;
    logic       cout1, ovf1, cout_q1, ovf_q1, seen1;
    logic [15:0] cnt1;

    // WIDTH=8 instance
    logic       rst8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic [7:0] sum8, sum_q8;
    logic       cout8, ovf8, cout_q8, ovf_q8, seen8;
    logic [15:0] cnt8;

    // WIDTH=16 instance
    logic        rst16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        cin16 = 1'b0;
    logic [15:0] sum16, sum_q16;
    logic        cout16, ovf16, cout_q16, ovf_q16, seen16;
    logic [15:0] cnt16;

    full_adder #(.WIDTH(1), .SIGNED_OVF(1'b1)) u_w1 (
        .clk(clk), .rst(rst1), .A(a1), .B(b1), .Cin(cin1),
        .Sum(sum1), .Cout(cout1), .Ovf(ovf1),
        .Sum_q(sum_q1), .Cout_q(cout_q1), .Ovf_q(ovf_q1),
        .carry_seen(seen1), .carry_cnt(cnt1)
    );

    full_adder #(.WIDTH(8), .SIGNED_OVF(1'b1)) u_w8 (
        .clk(clk), .rst(rst8), .A(a8), .B(b8), .Cin(cin8),
        .Sum(sum8), .Cout(cout8), .Ovf(ovf8),
        .Sum_q(sum_q8), .Cout_q(cout_q8), .Ovf_q(ovf_q8),
        .carry_seen(seen8), .carry_cnt(cnt8)
    );

    full_adder #(.WIDTH(16), .SIGNED_OVF(1'b1)) u_w16 (
        .clk(clk), .rst(rst16), .A(a16), .B(b16), .Cin(cin16),
        .Sum(sum16), .Cout(cout16), .Ovf(ovf16),
        .Sum_q(sum_q16), .Cout_q(cout_q16), .Ovf_q(ovf_q16),
        .carry_seen(seen16), .carry_cnt(cnt16)
    );

    // Reference: plain integer addition, signed overflow from the range of the
    // true signed result.
    function automatic void ref_add(input longint a, input longint b, input longint cin,
                                    input int w, output longint sum, output bit cout,
                                    output bit ovf);
        longint u, sa, sb, sv, lim;
        u    = a + b + cin;
        sum  = u & ((longint'(1) << w) - 1);
        cout = ((u >> w) & 1) != 0;
        sa   = ((a >> (w - 1)) & 1) != 0 ? a - (longint'(1) << w) : a;
        sb   = ((b >> (w - 1)) & 1) != 0 ? b - (longint'(1) << w) : b;
        sv   = sa + sb + cin;
        lim  = longint'(1) << (w - 1);
        ovf  = (sv >= lim) || (sv < -lim);
    endfunction

    // Exhaustive 1-bit truth table with clock idle and rst never driven.
    task automatic test_comb_w1();
        logic [1:0] exp_tab [8];
        logic [2:0] v3;
        longint es;
        bit ec, eo;
        exp_tab = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
        for (int v = 0; v < 8; v++) begin
            v3 = v[2:0];
            {a1, b1, cin1} = v3;
            #10;
            total++;
            if ({sum1, cout1} !== exp_tab[v]) begin
                bad++;
                $display("FAIL comb_w1 abc=%b sum,cout=%b%b expected %b", v3, sum1, cout1, exp_tab[v]);
            end
            ref_add(longint'(a1), longint'(b1), longint'(cin1), 1, es, ec, eo);
            total++;
            if (ovf1 !== eo) begin
                bad++;
                $display("FAIL ovf_w1 abc=%b ovf=%b expected %b", v3, ovf1, eo);
            end
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst8 = 1'b1; rst16 = 1'b1;
        #1;
        total++;
        if ({sum_q1, cout_q1, ovf_q1, seen1, cnt1} !== '0) begin
            bad++;
            $display("FAIL reset_w1 regs=%h expected 0", {sum_q1, cout_q1, ovf_q1, seen1, cnt1});
        end
        total++;
        if ({sum_q8, cout_q8, ovf_q8, seen8, cnt8} !== '0) begin
            bad++;
            $display("FAIL reset_w8 regs=%h expected 0", {sum_q8, cout_q8, ovf_q8, seen8, cnt8});
        end
        total++;
        if ({sum_q16, cout_q16, ovf_q16, seen16, cnt16} !== '0) begin
            bad++;
            $display("FAIL reset_w16 regs=%h expected 0", {sum_q16, cout_q16, ovf_q16, seen16, cnt16});
        end
        clk_run = 1'b1;
        @(negedge clk);
        rst1 = 1'b0; rst8 = 1'b0; rst16 = 1'b0;
    endtask

    // 1+1+0: carry appears at once, registered copy only after the next edge.
    task automatic test_latency();
        @(negedge clk);
        rst1 = 1'b1;
        #1;
        rst1 = 1'b0;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
        #1;
        total++;
        if (cout1 !== 1'b1 || sum1 !== 1'b0) begin
            bad++;
            $display("FAIL latency_comb sum=%b cout=%b expected 0 1", sum1, cout1);
        end
        total++;
        if (cout_q1 !== 1'b0 || seen1 !== 1'b0 || cnt1 !== 16'd0) begin
            bad++;
            $display("FAIL latency_pre cout_q=%b seen=%b cnt=%0d expected 0 0 0", cout_q1, seen1, cnt1);
        end
        @(posedge clk);
        #1;
        total++;
        if (sum_q1 !== 1'b0 || cout_q1 !== 1'b1 || seen1 !== 1'b1 || cnt1 !== 16'd1) begin
            bad++;
            $display("FAIL latency_post sum_q=%b cout_q=%b seen=%b cnt=%0d expected 0 1 1 1",
                     sum_q1, cout_q1, seen1, cnt1);
        end
    endtask

    task automatic test_w8_bounds();
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
        #1;
        total++;
        if (sum8 !== 8'h00 || cout8 !== 1'b1 || ovf8 !== 1'b0) begin
            bad++;
            $display("FAIL w8_ff_00_1 sum=%h cout=%b ovf=%b expected 00 1 0", sum8, cout8, ovf8);
        end
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        #1;
        total++;
        if (sum8 !== 8'h80 || cout8 !== 1'b0 || ovf8 !== 1'b1) begin
            bad++;
            $display("FAIL w8_7f_01_0 sum=%h cout=%b ovf=%b expected 80 0 1", sum8, cout8, ovf8);
        end
        @(posedge clk);
        #1;
        total++;
        if (sum_q8 !== 8'h80 || cout_q8 !== 1'b0 || ovf_q8 !== 1'b1) begin
            bad++;
            $display("FAIL w8_reg sum_q=%h cout_q=%b ovf_q=%b expected 80 0 1", sum_q8, cout_q8, ovf_q8);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst8 = 1'b1;
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
        #1;
        rst8 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (cnt8 !== 16'd5 || seen8 !== 1'b1 || cout_q8 !== 1'b1) begin
            bad++;
            $display("FAIL mid_count cnt=%0d seen=%b cout_q=%b expected 5 1 1", cnt8, seen8, cout_q8);
        end
        @(negedge clk);
        rst8 = 1'b1;
        #1;
        total++;
        if ({sum_q8, cout_q8, ovf_q8, seen8, cnt8} !== '0) begin
            bad++;
            $display("FAIL mid_reset_now regs=%h expected 0", {sum_q8, cout_q8, ovf_q8, seen8, cnt8});
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({sum_q8, cout_q8, ovf_q8, seen8, cnt8} !== '0) begin
            bad++;
            $display("FAIL mid_reset_held regs=%h expected 0", {sum_q8, cout_q8, ovf_q8, seen8, cnt8});
        end
        @(negedge clk);
        rst8 = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (cnt8 !== 16'd1 || seen8 !== 1'b1) begin
            bad++;
            $display("FAIL mid_resume cnt=%0d seen=%b expected 1 1", cnt8, seen8);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        rst16 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1;
        #1;
        rst16 = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        total++;
        if (cnt16 !== 16'hFFFE) begin
            bad++;
            $display("FAIL sat_pre cnt=%h expected fffe", cnt16);
        end
        @(posedge clk);
        #1;
        total++;
        if (cnt16 !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_reach cnt=%h expected ffff", cnt16);
        end
        @(posedge clk);
        #1;
        total++;
        if (cnt16 !== 16'hFFFF || seen16 !== 1'b1) begin
            bad++;
            $display("FAIL sat_hold cnt=%h seen=%b expected ffff 1", cnt16, seen16);
        end
    endtask

    task automatic test_random_w16();
        longint es, prev_sum;
        bit ec, eo, prev_c, prev_o;
        int exp_cnt;
        @(negedge clk);
        rst16 = 1'b1;
        a16 = '0; b16 = '0; cin16 = 1'b0;
        #1;
        rst16 = 1'b0;
        exp_cnt  = 0;
        prev_sum = 0; prev_c = 1'b0; prev_o = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a16   = 16'($urandom);
            b16   = 16'($urandom);
            cin16 = 1'($urandom);
            if (n % 10 == 0) a16 = 16'hFFFF - b16;   // push toward carry-chain edge cases
            ref_add(longint'(a16), longint'(b16), longint'(cin16), 16, es, ec, eo);
            #1;
            total++;
            if ({cout16, sum16} !== {ec, 16'(es)} || ovf16 !== eo) begin
                bad++;
                $display("FAIL rand_comb a=%h b=%h cin=%b got %b_%h ovf=%b expected %b_%h ovf=%b",
                         a16, b16, cin16, cout16, sum16, ovf16, ec, 16'(es), eo);
            end
            total++;
            if (sum_q16 !== 16'(prev_sum) || cout_q16 !== prev_c || ovf_q16 !== prev_o) begin
                bad++;
                $display("FAIL rand_lag sum_q=%h cout_q=%b ovf_q=%b expected %h %b %b",
                         sum_q16, cout_q16, ovf_q16, 16'(prev_sum), prev_c, prev_o);
            end
            @(posedge clk);
            #1;
            if (ec) exp_cnt++;
            prev_sum = es; prev_c = ec; prev_o = eo;
            total++;
            if (sum_q16 !== 16'(es) || cout_q16 !== ec || ovf_q16 !== eo || cnt16 !== 16'(exp_cnt)) begin
                bad++;
                $display("FAIL rand_reg sum_q=%h cout_q=%b ovf_q=%b cnt=%0d expected %h %b %b %0d",
                         sum_q16, cout_q16, ovf_q16, cnt16, 16'(es), ec, eo, exp_cnt);
            end
        end
        total++;
        if (seen16 !== (exp_cnt != 0)) begin
            bad++;
            $display("FAIL rand_seen seen=%b expected %b", seen16, exp_cnt != 0);
        end
    endtask

    initial begin
        test_comb_w1();
        test_reset();
        test_latency();
        test_w8_bounds();
        test_reset_mid();
        test_saturation();
        test_random_w16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
